// File: rtl/uart_bytes_rx.sv
// UART receiver that deserializes 12-bit words and assembles handshake + data words
// into a {mem, addr, data} memory-load command with a one-cycle valid strobe.
module uart_bytes_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned BYTE_COUNT   = 4,
  parameter int unsigned TIMEOUT_CLKS = 16 * CLKS_PER_BIT * (DATA_BITS + 2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [9+8*BYTE_COUNT:0]   data_out,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      proto_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned IDX_W = $clog2(BYTE_COUNT + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned DW    = 8 * BYTE_COUNT;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned LAST  = CLKS_PER_BIT - 1;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
  typedef enum logic {P_HUNT, P_COLLECT} pkt_state_e;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  bit_state_e           bit_state_q, bit_state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 word_rdy_c, stop_bad_c;
  logic [11:0]          word_c;

  pkt_state_e           pkt_state_q, pkt_state_d;
  logic                 mem_q, mem_d;
  logic [8:0]           addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [TO_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [9+DW:0]        data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 proto_err_q, proto_err_d;
  logic                 busy_q, busy_d;
  logic                 is_hdr_c, is_data_c;

  assign word_c    = shift_q[11:0];
  assign is_hdr_c  = (word_c[11:10] == 2'b01);
  assign is_data_c = (word_c[11:8] == 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      bit_state_q <= B_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pkt_state_q <= P_HUNT;
      mem_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      byte_idx_q  <= '0;
      idle_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      proto_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      bit_state_q <= bit_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pkt_state_q <= pkt_state_d;
      mem_q       <= mem_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      byte_idx_q  <= byte_idx_d;
      idle_cnt_q  <= idle_cnt_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      proto_err_q <= proto_err_d;
      busy_q      <= busy_d;
    end
  end

  // Bit-level deserializer: mid-bit sampling, LSB first.
  always_comb begin
    bit_state_d = bit_state_q;
    clk_cnt_d   = clk_cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_rdy_c  = 1'b0;
    stop_bad_c  = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) bit_state_d = B_START;
      end
      B_START: begin
        if (clk_cnt_q == CNT_W'(HALF)) begin
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
          bit_state_d = rx_s_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (clk_cnt_q == CNT_W'(LAST)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) bit_state_d = B_STOP;
        end
      end
      B_STOP: begin
        if (clk_cnt_q == CNT_W'(LAST)) begin
          clk_cnt_d   = '0;
          bit_state_d = B_IDLE;
          if (rx_s_q) word_rdy_c = 1'b1;
          else        stop_bad_c = 1'b1;
        end
      end
      default: bit_state_d = B_IDLE;
    endcase
  end

  // Packet assembler: header, BYTE_COUNT data bytes, resync and inter-word timeout.
  always_comb begin
    pkt_state_d = pkt_state_q;
    mem_d       = mem_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byte_idx_d  = byte_idx_q;
    idle_cnt_d  = '0;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    proto_err_d = 1'b0;
    busy_d      = busy_q;
    if (stop_bad_c) begin
      frame_err_d = 1'b1;
      pkt_state_d = P_HUNT;
      busy_d      = 1'b0;
    end else begin
      case (pkt_state_q)
        P_HUNT: begin
          if (word_rdy_c) begin
            if (is_hdr_c) begin
              mem_d       = word_c[9];
              addr_d      = word_c[8:0];
              data_d      = '0;
              byte_idx_d  = '0;
              pkt_state_d = P_COLLECT;
              busy_d      = 1'b1;
            end else begin
              proto_err_d = 1'b1;
            end
          end
        end
        P_COLLECT: begin
          if (word_rdy_c) begin
            if (is_data_c) begin
              for (int b = 0; b < int'(BYTE_COUNT); b++) begin
                if (byte_idx_q == IDX_W'(b)) data_d[8*b +: 8] = word_c[7:0];
              end
              byte_idx_d = byte_idx_q + IDX_W'(1);
              if (byte_idx_q == IDX_W'(BYTE_COUNT - 1)) begin
                data_out_d  = {mem_q, addr_q, data_d};
                valid_d     = 1'b1;
                pkt_state_d = P_HUNT;
                busy_d      = 1'b0;
              end
            end else if (is_hdr_c) begin
              proto_err_d = 1'b1;
              mem_d       = word_c[9];
              addr_d      = word_c[8:0];
              data_d      = '0;
              byte_idx_d  = '0;
            end else begin
              proto_err_d = 1'b1;
              pkt_state_d = P_HUNT;
              busy_d      = 1'b0;
            end
          end else if (bit_state_q == B_IDLE) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CLKS)) begin
              proto_err_d = 1'b1;
              pkt_state_d = P_HUNT;
              busy_d      = 1'b0;
            end else begin
              idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
          end
        end
        default: pkt_state_d = P_HUNT;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign proto_err = proto_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_bytes_rx.sv
// Self-checking bench for uart_bytes_rx: directed vector table, hand-written corner
// sequences, and randomized packet streams checked against a word-level packet model.
module tb_uart_bytes_rx;

  localparam int CPB = 16;
  localparam int TO  = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [41:0] data_out;
  logic        valid, frame_err, proto_err, busy;

  uart_bytes_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(12), .BYTE_COUNT(4), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .valid(valid),
    .frame_err(frame_err), .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int          obs_valid = 0, obs_frame = 0, obs_proto = 0;
  logic [41:0] obs_q[$];
  logic        valid_prev = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      obs_valid++;
      obs_q.push_back(data_out);
      check("valid_width", 64'(valid_prev), 64'd0);
    end
    if (frame_err || proto_err) check("err_exclusive", 64'(frame_err & proto_err), 64'd0);
    if (frame_err) obs_frame++;
    if (proto_err) obs_proto++;
    valid_prev = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serialize one word starting at a falling clock edge.
  task automatic send_word(input logic [11:0] w, input bit stop_ok, input int idle_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rx = w[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB * idle_bits) @(negedge clk);
  endtask

  // Word-level packet model.
  bit          m_in_pkt = 1'b0;
  logic        m_mem;
  logic [8:0]  m_addr;
  logic [31:0] m_data;
  int          m_n = 0;
  int          m_frame = 0, m_proto = 0;
  logic [41:0] exp_q[$];

  task automatic model_word(input logic [11:0] w, input bit stop_ok);
    if (!stop_ok) begin
      m_frame++;
      m_in_pkt = 1'b0;
    end else if (w[11:10] == 2'b01) begin
      if (m_in_pkt) m_proto++;
      m_in_pkt = 1'b1;
      m_mem = w[9];
      m_addr = w[8:0];
      m_data = '0;
      m_n = 0;
    end else if (!m_in_pkt) begin
      m_proto++;
    end else if (w[11:8] == 4'h0) begin
      m_data = m_data | (32'(w[7:0]) << (8 * m_n));
      m_n++;
      if (m_n == 4) begin
        exp_q.push_back({m_mem, m_addr, m_data});
        m_in_pkt = 1'b0;
      end
    end else begin
      m_proto++;
      m_in_pkt = 1'b0;
    end
  endtask

  // Directed vector table.
  typedef struct packed {
    logic [3:0]        n;
    logic [11:0][11:0] w;
    logic [11:0]       stop_ok;
    logic [1:0]        idle;
    logic [41:0]       exp_data;
    logic [1:0]        exp_valid;
    logic [1:0]        exp_frame;
    logic [1:0]        exp_proto;
  } vec_t;

  vec_t tbl[8];
  int   nv = 0;

  task automatic new_vec(input int idle, input logic [41:0] d, input int v, input int f, input int p);
    nv++;
    tbl[nv-1] = '0;
    tbl[nv-1].idle = 2'(idle);
    tbl[nv-1].exp_data = d;
    tbl[nv-1].exp_valid = 2'(v);
    tbl[nv-1].exp_frame = 2'(f);
    tbl[nv-1].exp_proto = 2'(p);
  endtask

  task automatic add(input logic [11:0] w, input bit ok);
    tbl[nv-1].w[tbl[nv-1].n] = w;
    tbl[nv-1].stop_ok[tbl[nv-1].n] = ok;
    tbl[nv-1].n = tbl[nv-1].n + 4'd1;
  endtask

  int bv, bf, bp;
  logic [41:0] held;

  initial begin
    new_vec(2, 42'h3A5DEADBEEF, 1, 0, 0);
    add(12'h7A5, 1); add(12'h0EF, 1); add(12'h0BE, 1); add(12'h0AD, 1); add(12'h0DE, 1);
    new_vec(2, 42'h00044332211, 1, 1, 0);
    add(12'h401, 1); add(12'h012, 0);
    add(12'h400, 1); add(12'h011, 1); add(12'h022, 1); add(12'h033, 1); add(12'h044, 1);
    new_vec(2, 42'h00104030201, 1, 0, 1);
    add(12'h7FF, 1); add(12'h0AA, 1);
    add(12'h401, 1); add(12'h001, 1); add(12'h002, 1); add(12'h003, 1); add(12'h004, 1);
    new_vec(2, 42'h0, 0, 0, 1);
    add(12'h0AA, 1);
    new_vec(1, 42'h0, 0, 0, 1);
    add(12'h401, 1); add(12'h011, 1); add(12'h8FF, 1);
    new_vec(0, 42'h012D4C3B2A1, 2, 0, 0);
    add(12'h6AB, 1); add(12'h011, 1); add(12'h022, 1); add(12'h033, 1); add(12'h044, 1);
    add(12'h412, 1); add(12'h0A1, 1); add(12'h0B2, 1); add(12'h0C3, 1); add(12'h0D4, 1);

    // Reset state.
    repeat (4) @(negedge clk);
    check("reset_outputs", 64'({data_out, valid, frame_err, proto_err, busy}), 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Directed table.
    for (int v = 0; v < nv; v++) begin
      bv = obs_valid; bf = obs_frame; bp = obs_proto; held = data_out;
      for (int i = 0; i < int'(tbl[v].n); i++)
        send_word(tbl[v].w[i], tbl[v].stop_ok[i], int'(tbl[v].idle));
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_valid", v), 64'(obs_valid - bv), 64'(tbl[v].exp_valid));
      check($sformatf("vec%0d_frame", v), 64'(obs_frame - bf), 64'(tbl[v].exp_frame));
      check($sformatf("vec%0d_proto", v), 64'(obs_proto - bp), 64'(tbl[v].exp_proto));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
      if (tbl[v].exp_valid != 0)
        check($sformatf("vec%0d_data", v), 64'(data_out), 64'(tbl[v].exp_data));
      else
        check($sformatf("vec%0d_data_held", v), 64'(data_out), 64'(held));
    end
    // Both back-to-back packets must have been seen in order.
    check("b2b_first", 64'(obs_q[obs_q.size()-2]), 64'h2AB44332211);

    // Busy spans header stop bit through valid.
    bv = obs_valid;
    send_word(12'h7A5, 1, 2);
    check("busy_after_hdr", 64'(busy), 64'd1);
    send_word(12'h0EF, 1, 2); send_word(12'h0BE, 1, 2); send_word(12'h0AD, 1, 2);
    check("busy_before_last", 64'(busy), 64'd1);
    send_word(12'h0DE, 1, 0);
    repeat (4) @(negedge clk);
    check("busy_after_valid", 64'(busy), 64'd0);
    check("busy_seq_valid", 64'(obs_valid - bv), 64'd1);

    // False start: short low glitch.
    bv = obs_valid; bf = obs_frame; bp = obs_proto;
    rx = 1'b0; repeat (4) @(negedge clk); rx = 1'b1;
    repeat (300) @(negedge clk);
    check("false_start_events", 64'((obs_valid - bv) + (obs_frame - bf) + (obs_proto - bp)), 64'd0);
    check("false_start_busy", 64'(busy), 64'd0);

    // Inter-word timeout after a lone header.
    bp = obs_proto; held = data_out;
    send_word(12'h401, 1, 0);
    repeat (950) @(negedge clk);
    check("timeout_not_early", 64'(obs_proto - bp), 64'd0);
    check("timeout_busy_held", 64'(busy), 64'd1);
    repeat (150) @(negedge clk);
    check("timeout_proto", 64'(obs_proto - bp), 64'd1);
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_data_held", 64'(data_out), 64'(held));

    // Reset in the middle of the third data word.
    send_word(12'h412, 1, 1); send_word(12'h0A1, 1, 1); send_word(12'h0B2, 1, 1);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mid_outputs", 64'({data_out, valid, frame_err, proto_err, busy}), 64'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    bv = obs_valid;
    send_word(12'h6AB, 1, 1); send_word(12'h001, 1, 1); send_word(12'h002, 1, 1);
    send_word(12'h003, 1, 1); send_word(12'h004, 1, 1);
    repeat (10) @(negedge clk);
    check("reset_new_valid", 64'(obs_valid - bv), 64'd1);
    check("reset_new_data", 64'(data_out), 64'h2AB04030201);

    // Randomized packet streams against the model.
    obs_q.delete(); exp_q.delete();
    bv = obs_valid; bf = obs_frame; bp = obs_proto;
    m_in_pkt = 1'b0; m_frame = 0; m_proto = 0;
    for (int p = 0; p < 20; p++) begin
      logic [11:0] words[5];
      int corrupt_at, kind;
      words[0] = {2'b01, 10'($urandom_range(0, 1023))};
      for (int i = 1; i < 5; i++) words[i] = {4'h0, 8'($urandom_range(0, 255))};
      kind = $urandom_range(0, 3);
      corrupt_at = $urandom_range(0, 4);
      for (int i = 0; i < 5; i++) begin
        logic [11:0] w;
        bit ok;
        int idle;
        w = words[i];
        ok = 1'b1;
        if (kind == 1 && i == corrupt_at) w = 12'($urandom_range(0, 4095));
        if (kind == 2 && i == corrupt_at) ok = 1'b0;
        idle = ok ? $urandom_range(0, 2) : 1;
        model_word(w, ok);
        send_word(w, ok, idle);
      end
    end
    repeat (20) @(negedge clk);
    if (m_in_pkt) begin
      repeat (TO + 100) @(negedge clk);
      m_proto++;
      m_in_pkt = 1'b0;
    end
    check("rand_valid_count", 64'(obs_valid - bv), 64'(exp_q.size()));
    check("rand_frame_count", 64'(obs_frame - bf), 64'(m_frame));
    check("rand_proto_count", 64'(obs_proto - bp), 64'(m_proto));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("rand_data%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    check("rand_busy_end", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
